s2p_rx: RTL and testbench

Serial-to-parallel receiver for the MSDAP 40-bit serial word link. It accepts an MSB-first bit stream framed by a qualifier, reassembles 40-bit words, and presents each completed word to a consumer through a valid/acknowledge holding register. It sits at the receiving end of the P2S output link: in loopback, the serial pair feeds this block, and PDATAOUT must equal the word originally loaded.

---
 rtl/msdap_pkg.sv | 5 +
 rtl/s2p_hold.sv | 28 ++
 rtl/s2p_rx.sv | 53 +++++
 tb/tb_s2p_rx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/msdap_pkg.sv
// msdap_pkg: shared constants and types for the MSDAP serial link
package msdap_pkg;
  localparam int WORD_W = 40;
  typedef enum logic {IDLE, SHIFT} s2p_state_t;
endpackage

// File: rtl/s2p_hold.sv
// s2p_hold: valid/acknowledge holding register with sticky overrun flag
module s2p_hold #(
  parameter int W = 40
) (
  input  logic         SCLK,
  input  logic         CLR,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         ack,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overrun
);
  // a new word wins over an ack; overwriting an unacknowledged word is sticky
  always_ff @(posedge SCLK) begin
    if (CLR) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (load) begin
      data    <= word;
      valid   <= 1'b1;
      overrun <= overrun | (valid & ~ack);
    end else if (ack) begin
      valid   <= 1'b0;
    end
  end
endmodule

// File: rtl/s2p_rx.sv
// s2p_rx: MSB-first serial-to-parallel receiver for the 40-bit word link
module s2p_rx
  import msdap_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             SCLK,
  input  logic             CLR,
  input  logic             DATAIN,
  input  logic             INREADY,
  input  logic             RDACK,
  output logic [WIDTH-1:0] PDATAOUT,
  output logic             WORDREADY,
  output logic             FRAMEERR,
  output logic             OVERRUN
);
  localparam int CW = $clog2(WIDTH + 1);
  s2p_state_t     state, state_n;
  logic [CW-1:0]  count, count_n;
  logic [WIDTH-1:0] sreg;
  logic           done, ferr_n;
  // completion returns to IDLE with count 0 so a still-high INREADY starts the next word
  always_comb begin
    done    = INREADY && (count == CW'(WIDTH - 1));
    state_n = (INREADY && !done) ? SHIFT : IDLE;
    count_n = (INREADY && !done) ? count + 1'b1 : '0;
    ferr_n  = (state == SHIFT) && !INREADY;
  end
  // state, bit counter, shift register and frame-error pulse
  always_ff @(posedge SCLK) begin
    if (CLR) begin
      state    <= IDLE;
      count    <= '0;
      sreg     <= '0;
      FRAMEERR <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      FRAMEERR <= ferr_n;
      if (INREADY) sreg <= {sreg[WIDTH-2:0], DATAIN};
    end
  end
  s2p_hold #(.W(WIDTH)) u_hold (
    .SCLK    (SCLK),
    .CLR     (CLR),
    .load    (done),
    .word    ({sreg[WIDTH-2:0], DATAIN}),
    .ack     (RDACK),
    .data    (PDATAOUT),
    .valid   (WORDREADY),
    .overrun (OVERRUN)
  );
endmodule

// File: tb/tb_s2p_rx.sv
// tb_s2p_rx: randomized self-checking bench for s2p_rx against a bit-queue model
module tb_s2p_rx;
  localparam int W = 40;
  logic         SCLK = 1'b0;
  logic         CLR = 1'b0;
  logic         DATAIN = 1'b0;
  logic         INREADY = 1'b0;
  logic         RDACK = 1'b0;
  logic [W-1:0] PDATAOUT;
  logic         WORDREADY;
  logic         FRAMEERR;
  logic         OVERRUN;
  int n_checks = 0;
  int n_fail = 0;
  bit           q[$];
  logic [W-1:0] m_data = '0;
  logic         m_wr = 1'b0;
  logic         m_fe = 1'b0;
  logic         m_ov = 1'b0;

  s2p_rx #(.WIDTH(W)) dut (
    .SCLK(SCLK), .CLR(CLR), .DATAIN(DATAIN), .INREADY(INREADY), .RDACK(RDACK),
    .PDATAOUT(PDATAOUT), .WORDREADY(WORDREADY), .FRAMEERR(FRAMEERR), .OVERRUN(OVERRUN)
  );

  always #5 SCLK = ~SCLK;

  task automatic step(input logic inr, input logic din, input logic ack, input logic clr);
    logic [W-1:0] w;
    bit fe_n, ld;
    INREADY = inr; DATAIN = din; RDACK = ack; CLR = clr;
    @(posedge SCLK);
    if (clr) begin
      q.delete();
      m_data = '0; m_wr = 0; m_fe = 0; m_ov = 0;
    end else begin
      fe_n = (q.size() > 0) && !inr;
      ld = 0;
      if (inr) begin
        q.push_back(din);
        if (q.size() == W) begin
          for (int i = 0; i < W; i++) w[W-1-i] = q[i];
          if (m_wr && !ack) m_ov = 1;
          m_data = w; m_wr = 1; ld = 1;
          q.delete();
        end
      end else q.delete();
      if (!ld && ack) m_wr = 0;
      m_fe = fe_n;
    end
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int ack_at);
    for (int i = 0; i < W; i++) step(1'b1, w[W-1-i], i == ack_at, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (PDATAOUT !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", PDATAOUT); end
    n_checks++; if (WORDREADY !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", WORDREADY); end
    n_checks++; if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL reset_fe got %b want 0", FRAMEERR); end
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_ov got %b want 0", OVERRUN); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_loopback();
    logic [W-1:0] w = 40'h80_0000_0001;
    for (int i = 0; i < W - 1; i++) step(1'b1, w[W-1-i], 1'b0, 1'b0);
    n_checks++; if (WORDREADY !== 1'b0) begin n_fail++; $display("FAIL lb_early_wr got %b want 0", WORDREADY); end
    step(1'b1, w[0], 1'b0, 1'b0);
    n_checks++; if (PDATAOUT !== w) begin n_fail++; $display("FAIL lb_data got %h want %h", PDATAOUT, w); end
    n_checks++; if (WORDREADY !== 1'b1) begin n_fail++; $display("FAIL lb_wr got %b want 1", WORDREADY); end
    n_checks++; if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL lb_fe got %b want 0", FRAMEERR); end
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL lb_ov got %b want 0", OVERRUN); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL lb_end_fe got %b want 0", FRAMEERR); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a = 40'hA5_5A5A_5A5A;
    logic [W-1:0] b = 40'h12_3456_789A;
    do_reset();
    send_word(a, -1);
    n_checks++; if (PDATAOUT !== a || WORDREADY !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %h/%b want %h/1", PDATAOUT, WORDREADY, a); end
    send_word(b, 0);
    n_checks++; if (PDATAOUT !== b || WORDREADY !== 1'b1) begin n_fail++; $display("FAIL b2b_second got %h/%b want %h/1", PDATAOUT, WORDREADY, b); end
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL b2b_ov got %b want 0", OVERRUN); end
    n_checks++; if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL b2b_fe got %b want 0", FRAMEERR); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    logic [W-1:0] a = {$urandom, $urandom} & {W{1'b1}};
    logic [W-1:0] b = {$urandom, $urandom} & {W{1'b1}};
    do_reset();
    send_word(a, -1);
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL ov_first got %b want 0", OVERRUN); end
    send_word(b, -1);
    n_checks++; if (PDATAOUT !== b) begin n_fail++; $display("FAIL ov_data got %h want %h", PDATAOUT, b); end
    n_checks++; if (WORDREADY !== 1'b1 || OVERRUN !== 1'b1) begin n_fail++; $display("FAIL ov_flags got %b%b want 11", WORDREADY, OVERRUN); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (WORDREADY !== 1'b0) begin n_fail++; $display("FAIL ov_ack_wr got %b want 0", WORDREADY); end
    n_checks++; if (OVERRUN !== 1'b1) begin n_fail++; $display("FAIL ov_sticky got %b want 1", OVERRUN); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (WORDREADY !== 1'b0 || OVERRUN !== 1'b1) begin n_fail++; $display("FAIL ov_idle_ack got %b%b want 01", WORDREADY, OVERRUN); end
  endtask

  task automatic test_ack_collision();
    logic [W-1:0] a = {$urandom, $urandom} & {W{1'b1}};
    logic [W-1:0] b = {$urandom, $urandom} & {W{1'b1}};
    do_reset();
    send_word(a, -1);
    send_word(b, W - 1);
    n_checks++; if (WORDREADY !== 1'b1) begin n_fail++; $display("FAIL col_wr got %b want 1", WORDREADY); end
    n_checks++; if (PDATAOUT !== b) begin n_fail++; $display("FAIL col_data got %h want %h", PDATAOUT, b); end
    n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL col_ov got %b want 0", OVERRUN); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_truncated();
    logic [W-1:0] a = {$urandom, $urandom} & {W{1'b1}};
    logic [W-1:0] c = {$urandom, $urandom} & {W{1'b1}};
    do_reset();
    send_word(a, -1);
    for (int i = 0; i < 17; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    n_checks++; if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL tr_early_fe got %b want 0", FRAMEERR); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (FRAMEERR !== 1'b1) begin n_fail++; $display("FAIL tr_fe got %b want 1", FRAMEERR); end
    n_checks++; if (PDATAOUT !== a || WORDREADY !== 1'b1) begin n_fail++; $display("FAIL tr_hold got %h/%b want %h/1", PDATAOUT, WORDREADY, a); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL tr_fe_len got %b want 0", FRAMEERR); end
    send_word(c, -1);
    n_checks++; if (PDATAOUT !== c || WORDREADY !== 1'b1 || OVERRUN !== 1'b0) begin n_fail++; $display("FAIL tr_next got %h/%b%b want %h/10", PDATAOUT, WORDREADY, OVERRUN, c); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] f = 40'hFF_FFFF_FFFF;
    send_word(40'h3C_C3C3_3C3C, -1);
    for (int i = 0; i < 19; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++; if (PDATAOUT !== '0 || WORDREADY !== 1'b0 || OVERRUN !== 1'b0 || FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL rm_outputs got %h/%b%b%b want 0/000", PDATAOUT, WORDREADY, OVERRUN, FRAMEERR); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL rm_fe got %b want 0", FRAMEERR); end
    send_word(f, -1);
    n_checks++; if (PDATAOUT !== f || WORDREADY !== 1'b1) begin n_fail++; $display("FAIL rm_next got %h/%b want %h/1", PDATAOUT, WORDREADY, f); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic inr = 1'b0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 99) < 3) inr = ~inr;
      else if (!inr && $urandom_range(0, 9) < 3) inr = 1'b1;
      step(inr, 1'($urandom), $urandom_range(0, 99) < 5, $urandom_range(0, 999) < 3);
      n_checks++; if (PDATAOUT !== m_data) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", c, PDATAOUT, m_data); end
      n_checks++; if (WORDREADY !== m_wr) begin n_fail++; $display("FAIL rnd_wr cyc %0d got %b want %b", c, WORDREADY, m_wr); end
      n_checks++; if (FRAMEERR !== m_fe) begin n_fail++; $display("FAIL rnd_fe cyc %0d got %b want %b", c, FRAMEERR, m_fe); end
      n_checks++; if (OVERRUN !== m_ov) begin n_fail++; $display("FAIL rnd_ov cyc %0d got %b want %b", c, OVERRUN, m_ov); end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_overrun();
    test_ack_collision();
    test_truncated();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
